// File: rtl/sd_crc_unit.sv
// sd_crc_unit: frame-aware serial CRC generator/checker for the SD SPI path.
// One bit per strobe, MSB-first, non-reflected, no output XOR. A frame is
// DATA_BITS data bits, optionally followed by CRC_W received CRC bits that are
// fed through the same register and checked for a zero residue.
//
// Build option: define SD_CRC_CHECK_EN to include the CHECK phase. Without it
// the unit is generate-only: the frame ends after the data field and crc_ok
// is tied low.
module sd_crc_unit #(
   parameter int unsigned CRC_W = 16,
   parameter logic [CRC_W-1:0] POLY = CRC_W'(16'h1021),
   parameter logic [CRC_W-1:0] INIT = '0,
   parameter int unsigned DATA_BITS = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc_out,
   output logic             busy,
   output logic             done,
   output logic             crc_ok
);

   // The counter is shared by both phases, so it must hold either bound.
   localparam int unsigned DataCntW = $clog2(DATA_BITS + 1);
   localparam int unsigned ChkCntW  = $clog2(CRC_W + 1);
   localparam int unsigned CntW     = (DataCntW > ChkCntW) ? DataCntW : ChkCntW;
   localparam logic [CntW-1:0] LastData = CntW'(DATA_BITS - 1);
`ifdef SD_CRC_CHECK_EN
   localparam logic [CntW-1:0] LastChk  = CntW'(CRC_W - 1);
`endif

`ifdef SD_CRC_CHECK_EN
   typedef enum logic [1:0] {StIdle, StData, StCheck} state_e;
`else
   typedef enum logic [1:0] {StIdle, StData} state_e;
`endif

   state_e           state_q, state_d;
   logic [CRC_W-1:0] crc_q, crc_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [CRC_W-1:0] crc_out_q, crc_out_d;
   logic             done_q, done_d;
`ifdef SD_CRC_CHECK_EN
   logic             crc_ok_q, crc_ok_d;
`endif

   logic             fb;
   logic [CRC_W-1:0] crc_next;

   // One LFSR step of the CRC register for the bit currently on bit_in.
   always_comb begin
      fb       = bit_in ^ crc_q[CRC_W-1];
      crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
   end

   // State register and datapath flops, asynchronously cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         crc_q     <= INIT;
         cnt_q     <= '0;
         crc_out_q <= '0;
         done_q    <= 1'b0;
`ifdef SD_CRC_CHECK_EN
         crc_ok_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         cnt_q     <= cnt_d;
         crc_out_q <= crc_out_d;
         done_q    <= done_d;
`ifdef SD_CRC_CHECK_EN
         crc_ok_q  <= crc_ok_d;
`endif
      end
   end

   // Next-state logic: start overrides everything, including a bit presented
   // in the same cycle; otherwise accepted bits advance the current phase.
   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      cnt_d     = cnt_q;
      crc_out_d = crc_out_q;
      done_d    = 1'b0;
`ifdef SD_CRC_CHECK_EN
      crc_ok_d  = crc_ok_q;
`endif

      if (start) begin
         state_d = StData;
         crc_d   = INIT;
         cnt_d   = '0;
`ifdef SD_CRC_CHECK_EN
         crc_ok_d = 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               // Stray bits between frames are ignored.
            end
            StData: begin
               if (bit_valid) begin
                  crc_d = crc_next;
                  if (cnt_q == LastData) begin
                     crc_out_d = crc_next;
                     cnt_d     = '0;
`ifdef SD_CRC_CHECK_EN
                     state_d   = StCheck;
`else
                     state_d   = StIdle;
                     done_d    = 1'b1;
`endif
                  end else begin
                     cnt_d = cnt_q + CntW'(1);
                  end
               end
            end
`ifdef SD_CRC_CHECK_EN
            StCheck: begin
               // Received CRC bits run through the register; a correct
               // trailer leaves an all-zero residue.
               if (bit_valid) begin
                  crc_d = crc_next;
                  if (cnt_q == LastChk) begin
                     cnt_d    = '0;
                     state_d  = StIdle;
                     done_d   = 1'b1;
                     crc_ok_d = (crc_next == '0);
                  end else begin
                     cnt_d = cnt_q + CntW'(1);
                  end
               end
            end
`endif
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Outputs are taken straight from state so they are glitch-free.
   always_comb begin
      busy    = (state_q != StIdle);
      done    = done_q;
      crc_out = crc_out_q;
`ifdef SD_CRC_CHECK_EN
      crc_ok  = crc_ok_q;
`else
      crc_ok  = 1'b0;
`endif
   end

   // busy drops on the same edge that raises done.
   a_done_not_busy : assert property (@(posedge clk) disable iff (reset) done |-> !busy);
   // A start always leaves the unit in a frame on the next cycle.
   a_start_busy : assert property (@(posedge clk) disable iff (reset) start |=> busy);

endmodule

// File: doc/sd_crc_unit.md
# sd_crc_unit

Parametrised, frame-aware CRC generator/checker for the SD-card SPI path. It accepts one serial bit per strobe on the system clock and accumulates a CRC of configurable width and polynomial over a fixed-length data field. It can then optionally absorb the CRC_W trailing CRC bits from the line and report match/mismatch. It sits beside the SPI shifter and serves both CRC7 (command tokens) and CRC16 (data blocks) instances.

## Interface
Parameters:
- CRC_W, 16, CRC register width (2..32); 7 for command CRC, 16 for data CRC
- POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term, MSB-first, non-reflected
- INIT, 0, register value loaded on start
- DATA_BITS, 4096, data bits per frame before the CRC field (>= 1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  reset, asynchronous, active-high
- start  input  1  single-cycle pulse: load INIT, clear counters, enter DATA
- bit_valid  input  1  bit_in is valid this cycle
- bit_in  input  1  serial bit, MSB-first as on the SPI line
- crc_out  output  CRC_W  CRC of the data field; frozen at end of DATA
- busy  output  1  high in DATA or CHECK
- done  output  1  one-cycle pulse at frame completion
- crc_ok  output  1  CHECK result; valid from done until next start

## Operation
- State register: crc_reg[CRC_W-1:0]. Bit counter: width $clog2(DATA_BITS+1).
- Update per accepted bit: fb = bit_in ^ crc_reg[CRC_W-1]; crc_reg <= {crc_reg[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
- FSM: IDLE, DATA, CHECK.
  - IDLE: bit_valid ignored. start -> DATA, crc_reg <= INIT, cnt <= 0, crc_ok <= 0.
  - DATA: each bit_valid updates crc_reg and increments cnt. On the DATA_BITS-th bit, crc_out <= updated crc_reg, cnt <= 0, -> CHECK.
  - CHECK: each bit_valid keeps updating crc_reg (received CRC bits fed through). On the CRC_W-th bit -> IDLE, done=1, crc_ok <= (updated crc_reg == 0).
- Zero residue is the pass criterion. It is valid because no reflection and no output XOR are applied.
- start in any state, including busy, aborts the current frame and restarts it. No done is produced for the aborted frame.
- start and bit_valid in the same cycle: start wins, the bit is discarded.
- bit_valid gaps of any length are permitted. State holds while bit_valid=0.

## Timing
- Reset values: crc_out=0, busy=0, done=0, crc_ok=0, FSM=IDLE, crc_reg=INIT, cnt=0.
- Reset asserted mid-frame returns all of the above immediately (asynchronous). No done is produced.
- busy rises the cycle after start and falls in the same cycle done rises.
- crc_out is updated the cycle after the last data bit is accepted. It holds until the next frame's DATA completes.
- done is high for exactly the one cycle after the last CRC bit is accepted. crc_ok updates on the same edge.
- Throughput: one bit per clk. A back-to-back start is accepted in the cycle done is high.

## Configuration
- SD_CRC_CHECK_EN defined: CHECK state present, behaviour as above.
- SD_CRC_CHECK_EN undefined:
  - No CHECK state. The DATA_BITS-th bit goes directly to IDLE with done=1.
  - crc_ok is tied to 0.
  - crc_out behaves identically. This is the generate-only build used on the transmit side.

## Test plan
- CRC_W=7, POLY=7'h09, INIT=0, DATA_BITS=40, CMD0 bytes 40 00 00 00 00 -> crc_out=7'h4A one cycle after bit 40.
- Same config, CMD8 bytes 48 00 00 01 AA, then 7 bits 7'h43 (check enabled) -> crc_out=7'h43, done pulse, crc_ok=1.
- Defaults, 512 bytes 0xFF, then 16'h7FA1 -> crc_out=16'h7FA1, crc_ok=1. Repeat with trailing 16'h7FA0 -> crc_ok=0.
- Defaults, random bit_valid gaps (0-5 idle cycles) during the 0xFF frame -> results identical to the gapless run.
- start asserted after 100 data bits, then a full 0xFF frame -> no done at abort; final crc_out=16'h7FA1. A bit presented with start is ignored.
- reset pulsed during CHECK -> busy=0, done never pulses, crc_out=0, crc_ok=0. The next full frame yields correct results.
